// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag-vector indices for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_C    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/cla_slice.sv
// One CLA_W-bit carry-lookahead slice; AND_OUT exposes the generate terms for the AND opcode.
module cla_slice #(
    parameter int CLA_W = 4
) (
    input  logic [CLA_W-1:0] A,
    input  logic [CLA_W-1:0] B,
    input  logic             CIN,
    output logic [CLA_W-1:0] SUM,
    output logic             COUT,
    output logic [CLA_W-1:0] AND_OUT
);

    logic [CLA_W-1:0] p;
    logic [CLA_W-1:0] g;
    logic [CLA_W:0]   c;

    assign p       = A ^ B;
    assign g       = A & B;
    assign AND_OUT = g;

    // Each carry is expanded from CIN independently, so no carry depends on a sibling carry.
    always_comb begin
        logic t;
        c = '0;
        for (int i = 0; i <= CLA_W; i++) begin
            t = CIN;
            for (int j = 0; j < i; j++)
                t = g[j] | (p[j] & t);
            c[i] = t;
        end
    end

    assign SUM  = p ^ c[CLA_W-1:0];
    assign COUT = c[CLA_W];

endmodule

// File: rtl/alu_seq.sv
// Registered signed ALU with valid/ready ports; the shift-add multiplier is built only
// when ALU_SEQ_MUL_EN is defined, otherwise opcode 110 is PASS A flagged as illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int CLA_W = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       CTRL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZEROFLAG,
    output logic             NEGATIVEFLAG,
    output logic             CARRYFLAG,
    output logic             OVERFLOWFLAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int NSL = WIDTH / CLA_W;
    localparam int MSB = WIDTH - 1;

    state_t               state, state_nxt;
    logic                 accept, out_fire, mul_start;
    logic [WIDTH-1:0]     result_q;
    logic [NUM_FLAGS-1:0] flags_q;
    logic                 out_valid_q;

    assign accept   = IN_VALID && IN_READY;
    assign out_fire = OUT_VALID && OUT_READY;

    // Single-cycle datapath
    logic             is_sub;
    logic [WIDTH-1:0] bop, sum, and_v, res_c;
    logic [NSL:0]     carry;
    logic             c_c, v_c;

    assign is_sub   = (CTRL == OP_SUB);
    assign bop      = is_sub ? ~B : B;
    assign carry[0] = is_sub;

    genvar gi;
    generate
        for (gi = 0; gi < NSL; gi++) begin : g_cla
            cla_slice #(.CLA_W(CLA_W)) u_slice (
                .A       (A[gi*CLA_W +: CLA_W]),
                .B       (bop[gi*CLA_W +: CLA_W]),
                .CIN     (carry[gi]),
                .SUM     (sum[gi*CLA_W +: CLA_W]),
                .COUT    (carry[gi+1]),
                .AND_OUT (and_v[gi*CLA_W +: CLA_W])
            );
        end
    endgenerate

    always_comb begin
        res_c = A;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (CTRL)
            OP_ADD, OP_SUB: begin
                res_c = sum;
                c_c   = carry[NSL];
                v_c   = (A[MSB] == bop[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_AND: res_c = and_v;
            OP_OR:  res_c = A | B;
            OP_XOR: res_c = A ^ B;
`ifndef ALU_SEQ_MUL_EN
            OP_MUL: v_c = 1'b1;
`endif
            default: res_c = A;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef struct packed {
        logic [2*WIDTH-1:0] mcand;
        logic [WIDTH-1:0]   mplier;
        logic               neg;
    } mul_ctx_t;

    mul_ctx_t           ctx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH:0]     prod_hi;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               mul_ovf;

    assign mul_start = accept && (CTRL == OP_MUL);
    // The most negative operand negates to itself, which reads as 2^(WIDTH-1) unsigned.
    assign a_abs     = A[MSB] ? (~A + 1'b1) : A;
    assign b_abs     = B[MSB] ? (~B + 1'b1) : B;
    assign prod      = ctx.neg ? (~acc + 1'b1) : acc;
    assign prod_hi   = prod[2*WIDTH-1:WIDTH-1];
    assign mul_ovf   = !((&prod_hi) || !(|prod_hi));

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ctx <= '0;
            cnt <= '0;
            acc <= '0;
        end else if (state == ST_IDLE) begin
            if (mul_start) begin
                ctx.mcand  <= {{WIDTH{1'b0}}, a_abs};
                ctx.mplier <= b_abs;
                ctx.neg    <= A[MSB] ^ B[MSB];
                cnt        <= '0;
                acc        <= '0;
            end
        end else if (state == ST_MUL) begin
            if (ctx.mplier[0])
                acc <= acc + ctx.mcand;
            ctx.mcand  <= ctx.mcand << 1;
            ctx.mplier <= ctx.mplier >> 1;
            cnt        <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end
`else
    assign mul_start = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (!RESETN)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
        case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_MUL;
            default: state_nxt = ST_IDLE;
        endcase
`endif
    end

    // FSM: outputs (RESETN gate keeps IN_READY low during the reset cycle itself)
    always_comb begin
        IN_READY = RESETN && (state == ST_IDLE) && (!out_valid_q || OUT_READY);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_fire)
                out_valid_q <= 1'b0;
            if (accept && !mul_start) begin
                result_q        <= res_c;
                flags_q[FLAG_Z] <= ~|res_c;
                flags_q[FLAG_N] <= res_c[MSB];
                flags_q[FLAG_C] <= c_c;
                flags_q[FLAG_V] <= v_c;
                out_valid_q     <= 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            if (state == ST_DONE) begin
                result_q        <= prod[WIDTH-1:0];
                flags_q[FLAG_Z] <= ~|prod[WIDTH-1:0];
                flags_q[FLAG_N] <= prod[MSB];
                flags_q[FLAG_C] <= 1'b0;
                flags_q[FLAG_V] <= mul_ovf;
                out_valid_q     <= 1'b1;
            end
`endif
        end
    end

    assign RESULT       = result_q;
    assign ZEROFLAG     = flags_q[FLAG_Z];
    assign NEGATIVEFLAG = flags_q[FLAG_N];
    assign CARRYFLAG    = flags_q[FLAG_C];
    assign OVERFLOWFLAG = flags_q[FLAG_V];
    assign OUT_VALID    = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 12;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic [2:0]   CTRL = '0;
    logic         IN_VALID = 1'b0, OUT_READY = 1'b0;
    logic         IN_READY, OUT_VALID;
    logic [W-1:0] RESULT;
    logic         ZEROFLAG, NEGATIVEFLAG, CARRYFLAG, OVERFLOWFLAG;

    int n_chk = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(W), .CLA_W(4)) dut (
        .CLK(CLK), .RESETN(RESETN), .A(A), .B(B), .CTRL(CTRL),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .RESULT(RESULT),
        .ZEROFLAG(ZEROFLAG), .NEGATIVEFLAG(NEGATIVEFLAG), .CARRYFLAG(CARRYFLAG),
        .OVERFLOWFLAG(OVERFLOWFLAG), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {V, C, N, Z, result}
    function automatic logic [W+3:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [2:0] op);
        longint sa, sb, r;
        logic [W-1:0] res;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0;
        c = 1'b0;
        v = 1'b0;
        res = a;
        case (op)
            OP_ADD: begin
                r = sa + sb;
                c = (longint'(a) + longint'(b)) >= (longint'(1) << W);
            end
            OP_SUB: begin
                r = sa - sb;
                c = longint'(a) >= longint'(b);
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: r = sa * sb;
`else
            OP_MUL: v = 1'b1;
`endif
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            default: res = a;
        endcase
        if (op == OP_ADD || op == OP_SUB
`ifdef ALU_SEQ_MUL_EN
            || op == OP_MUL
`endif
           ) begin
            res = r[W-1:0];
            v = (r > (longint'(1) << (W-1)) - 1) || (r < -(longint'(1) << (W-1)));
        end
        return {v, c, res[W-1], (res == '0), res};
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] x;
        case ($urandom_range(0, 7))
            0: x = '0;
            1: x = W'(1);
            2: x = '1;
            3: x = {1'b0, {(W-1){1'b1}}};
            4: x = {1'b1, {(W-1){1'b0}}};
            default: x = W'($urandom);
        endcase
        return x;
    endfunction

    function automatic logic [3:0] dut_flags();
        return {OVERFLOWFLAG, CARRYFLAG, NEGATIVEFLAG, ZEROFLAG};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          input int dly);
        logic [W+3:0] e;
        int lat, to, explat;
        e = ref_model(a, b, op);
        explat = 1;
`ifdef ALU_SEQ_MUL_EN
        if (op == OP_MUL) explat = W + 1;
`endif
        @(negedge CLK);
        A = a; B = b; CTRL = op; IN_VALID = 1'b1; OUT_READY = (dly == 0);
        #1;
        to = 0;
        while (!IN_READY && to < 20) begin
            @(negedge CLK); #1; to++;
        end
        chk("in_ready", 64'(IN_READY), 64'(1));
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        A = W'($urandom); B = W'($urandom); CTRL = 3'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge CLK);
            lat++;
            if (OUT_VALID) break;
            chk("busy_in_ready", 64'(IN_READY), 64'(0));
        end
        chk("latency", 64'(lat), 64'(explat));
        chk("result", 64'(RESULT), 64'(e[W-1:0]));
        chk("flags", 64'(dut_flags()), 64'(e[W+3:W]));
        for (int k = 0; k < dly; k++) begin
            @(negedge CLK);
            chk("hold_result", 64'(RESULT), 64'(e[W-1:0]));
            chk("hold_flags", 64'(dut_flags()), 64'(e[W+3:W]));
            chk("hold_valid", 64'(OUT_VALID), 64'(1));
            chk("hold_in_ready", 64'(IN_READY), 64'(0));
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        chk("drain", 64'(OUT_VALID), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   bops [4];
        logic [W-1:0] ba [4], bb [4];
        logic [W+3:0] be [4];
        logic [W+3:0] ex, ey;
        int seen;

        // Reset state
        RESETN = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready", 64'(IN_READY), 64'(0));
        @(negedge CLK);
        chk("rst_out_valid", 64'(OUT_VALID), 64'(0));
        chk("rst_result", 64'(RESULT), 64'(0));
        chk("rst_flags", 64'(dut_flags()), 64'(0));
        RESETN = 1'b1;
        @(negedge CLK);
        chk("rel_in_ready", 64'(IN_READY), 64'(1));

        // Directed boundaries
        run_op(W'(2047), W'(1), OP_ADD, 0);
        run_op(W'(5), W'(5), OP_SUB, 0);
        run_op(W'(0), W'(1), OP_SUB, 1);
        run_op(12'h800, W'(1), OP_SUB, 0);
        run_op(W'(123), W'(77), OP_MUL, 0);
        run_op(12'hFF9, W'(6), OP_MUL, 0);
        run_op(12'h800, 12'hFFF, OP_MUL, 2);
        run_op(12'h123, W'(0), OP_MUL, 0);
        run_op(12'h5A5, 12'h0F0, OP_NOP, 0);

        // Back-to-back single-cycle ops with OUT_READY held high
        bops[0] = OP_ADD; bops[1] = OP_AND; bops[2] = OP_OR; bops[3] = OP_XOR;
        for (int i = 0; i < 4; i++) begin
            ba[i] = W'($urandom); bb[i] = W'($urandom);
            be[i] = ref_model(ba[i], bb[i], bops[i]);
        end
        @(negedge CLK);
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                chk("b2b_valid", 64'(OUT_VALID), 64'(1));
                chk("b2b_result", 64'(RESULT), 64'(be[i-1][W-1:0]));
                chk("b2b_flags", 64'(dut_flags()), 64'(be[i-1][W+3:W]));
            end
            A = ba[i]; B = bb[i]; CTRL = bops[i]; IN_VALID = 1'b1;
            #1;
            chk("b2b_in_ready", 64'(IN_READY), 64'(1));
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        chk("b2b_valid", 64'(OUT_VALID), 64'(1));
        chk("b2b_result", 64'(RESULT), 64'(be[3][W-1:0]));
        @(posedge CLK); #1;
        chk("b2b_drain", 64'(OUT_VALID), 64'(0));

        // Backpressure: result holds and the next op waits
        ex = ref_model(12'h3C3, 12'h0FF, OP_SUB);
        ey = ref_model(12'h00F, 12'h0F1, OP_OR);
        @(negedge CLK);
        A = 12'h3C3; B = 12'h0FF; CTRL = OP_SUB; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(negedge CLK);
        A = 12'h00F; B = 12'h0F1; CTRL = OP_OR;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_valid", 64'(OUT_VALID), 64'(1));
            chk("stall_result", 64'(RESULT), 64'(ex[W-1:0]));
            chk("stall_in_ready", 64'(IN_READY), 64'(0));
            if (k < 2) @(negedge CLK);
        end
        OUT_READY = 1'b1;
        #1;
        chk("unstall_in_ready", 64'(IN_READY), 64'(1));
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("unstall_result", 64'(RESULT), 64'(ey[W-1:0]));
        chk("unstall_valid", 64'(OUT_VALID), 64'(1));
        @(posedge CLK); #1;

        // Reset while an operation is in flight; nothing may emerge afterwards
        @(negedge CLK);
        A = 12'hFF9; B = W'(6); CTRL = OP_MUL; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESETN = 1'b0;
        @(negedge CLK);
        chk("midrst_in_ready", 64'(IN_READY), 64'(0));
        chk("midrst_valid", 64'(OUT_VALID), 64'(0));
        @(negedge CLK);
        chk("midrst_result", 64'(RESULT), 64'(0));
        RESETN = 1'b1;
        @(negedge CLK);
        chk("midrst_rel_ready", 64'(IN_READY), 64'(1));
        seen = 0;
        repeat (W + 4) begin
            @(negedge CLK);
            if (OUT_VALID) seen++;
        end
        chk("abort_no_output", 64'(seen), 64'(0));
        OUT_READY = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 150; i++)
            run_op(pick(), pick(), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
